div_rem_unit: RTL and testbench

- Multi-cycle integer divide/remainder execution unit for the core datapath.
- Responds to the DIV/DIVU/REM/REMU operations issued by the decoder: alucontrol 4'b1101 selects quotient, 4'b1110 selects remainder, and signed_op selects signed or unsigned.
- Computes one quotient bit per cycle with restoring radix-2 division.
- Holds the pipeline through a stall output until the result is ready.

---
 rtl/div_rem_unit.sv | 200 ++++++++++++++++++++
 tb/tb_div_rem_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_rem_unit.sv
// div_rem_unit: multi-cycle integer divide/remainder unit.
// One quotient bit per cycle using restoring radix-2 division on operand
// magnitudes, with a sign-fix cycle at the end. Divide-by-zero and signed
// overflow bypass the iteration through a single SPECIAL state.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a DIV/DIVU/REM/REMU request
//   RUN     | one restoring-division step per cycle, counter counts down
//   FIX     | apply operand signs, load result with quotient or remainder
//   SPECIAL | divide-by-zero or signed overflow, load fixed result
//   DONE    | result valid, done pulse, pipeline released
module div_rem_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alucontrol,
  input  logic            signed_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] ALU_DIV = 4'b1101;
  localparam logic [3:0] ALU_REM = 4'b1110;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_FIX     = 3'd2,
    S_SPECIAL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            op_rem_q,  op_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q,    div0_d;
  logic [XLEN-1:0] a_q,       a_d;
  logic [XLEN-1:0] dvd_q,     dvd_d;
  logic [XLEN-1:0] dvs_q,     dvs_d;
  logic [XLEN:0]   rem_q,     rem_d;
  logic [XLEN-1:0] result_q,  result_d;

  logic            is_div_op;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            overflow;
  logic [XLEN+1:0] trial;
  logic            trial_ok;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  // Request decode, operand magnitudes and special-case detection
  always_comb begin
    is_div_op = (alucontrol == ALU_DIV) || (alucontrol == ALU_REM);
    accept    = start && (state_q == S_IDLE) && is_div_op;
    a_neg     = signed_op && operand_a[XLEN-1];
    b_neg     = signed_op && operand_b[XLEN-1];
    // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude
    a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;
    b_zero    = (operand_b == '0);
    overflow  = signed_op && (operand_a == MIN_NEG) && (operand_b == ALL_ONES);
  end

  // One restoring step: shift in next dividend MSB, trial-subtract divisor.
  // Top remainder bit is always 0 between steps; it is kept in the trial so
  // the full register participates.
  always_comb begin
    trial     = {rem_q, dvd_q[XLEN-1]} - {2'b00, dvs_q};
    trial_ok  = ~trial[XLEN+1];
    quo_fixed = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_fixed = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_d       = a_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_rem_d  = (alucontrol == ALU_REM);
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = b_zero;
          a_d       = operand_a;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          if (b_zero || overflow) begin
            state_d = S_SPECIAL;
          end else begin
            state_d = S_RUN;
            cnt_d   = CW'(XLEN - 1);
          end
        end
      end

      S_RUN: begin
        if (trial_ok) begin
          rem_d = trial[XLEN:0];
        end else begin
          rem_d = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
        end
        dvd_d = {dvd_q[XLEN-2:0], trial_ok};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        result_d = op_rem_q ? rem_fixed : quo_fixed;
        state_d  = S_DONE;
      end

      S_SPECIAL: begin
        if (div0_q) begin
          result_d = op_rem_q ? a_q : ALL_ONES;
        end else begin
          result_d = op_rem_q ? '0 : MIN_NEG;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_q       <= a_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  // Status outputs decoded from the registered state; stall releases in DONE
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    stall  = accept || (busy && !done);
    result = result_q;
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// Self-checking bench for div_rem_unit: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_div_rem_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [3:0]      alucontrol;
  logic            signed_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  int n_cmp;
  int n_err;
  logic [XLEN-1:0] last_exp;

  div_rem_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .alucontrol(alucontrol),
    .signed_op(signed_op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .stall(stall),
    .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V divide semantics, straight from the arithmetic definition
  function automatic logic [XLEN-1:0] ref_result(input bit is_rem, input bit sgn,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    int sa;
    int sb;
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
      sa = a;
      sb = b;
      if (is_rem) return 32'(sa % sb);
      return 32'(sa / sb);
    end
    if (is_rem) return a % b;
    return a / b;
  endfunction

  function automatic bit is_special(input bit sgn, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Entered and left at a negedge. poke_cyc: cycle (after accept) in which a
  // stray start is driven; rst_cyc: cycle in which reset is asserted.
  task automatic run_op(input string tag, input bit is_rem, input bit sgn,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int poke_cyc, input int rst_cyc);
    int cyc;
    int exp_lat;
    logic [XLEN-1:0] exp_res;
    exp_res = ref_result(is_rem, sgn, a, b);
    exp_lat = is_special(sgn, a, b) ? 2 : XLEN + 2;
    start      = 1'b1;
    alucontrol = is_rem ? 4'b1110 : 4'b1101;
    signed_op  = sgn;
    operand_a  = a;
    operand_b  = b;
    #1;
    check({tag, "_stall_accept"}, 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        check({tag, "_rst_done"}, 64'(done), 64'd0);
        check({tag, "_rst_stall"}, 64'(stall), 64'd0);
        check({tag, "_rst_result"}, 64'(result), 64'(last_exp));
        return;
      end
      if (done) break;
      if (cyc == poke_cyc) begin
        start      = 1'b1;
        alucontrol = 4'b1101;
        signed_op  = 1'b1;
        operand_a  = $urandom;
        operand_b  = 32'd0;
      end
      @(negedge clk);
      start = 1'b0;
      if (cyc == poke_cyc) check({tag, "_poke_busy"}, 64'(busy), 64'd1);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    last_exp = exp_res;
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    bit r_rem;
    bit r_sgn;
    int sel;
    n_cmp = 0;
    n_err = 0;
    last_exp = '0;
    rst = 1'b1;
    start = 1'b0;
    alucontrol = 4'b0000;
    signed_op = 1'b0;
    operand_a = '0;
    operand_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 0, 0);
    run_op("remu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 0, 0);
    check("remu_100_7_value", 64'(last_exp), 64'd2);
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op("divu_5_0", 1'b0, 1'b0, 32'd5, 32'd0, 0, 0);
    run_op("rem_5_0", 1'b1, 1'b1, 32'd5, 32'd0, 0, 0);
    run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_min_2", 1'b0, 1'b1, 32'h8000_0000, 32'd2, 0, 0);
    run_op("divu_max_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);

    // Start with a non-divide opcode is ignored
    start = 1'b1;
    alucontrol = 4'b0000;
    operand_a = 32'd9;
    operand_b = 32'd3;
    #1;
    check("ign_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd0);
    check("ign_result", 64'(result), 64'(last_exp));

    // Stray start mid-run is ignored
    run_op("poke_divu", 1'b0, 1'b0, 32'd100, 32'd7, 5, 0);
    // Reset mid-run, then an immediate new op
    run_op("rst_divu", 1'b0, 1'b0, 32'd12345, 32'd11, 0, 10);
    run_op("after_rst", 1'b1, 1'b0, 32'd12345, 32'd11, 0, 0);

    for (int i = 0; i < 60; i++) begin
      r_rem = 1'($urandom);
      r_sgn = 1'($urandom);
      ra = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel < 6) rb = 32'($urandom_range(1, 20));
      else if (sel < 8) rb = -32'($urandom_range(1, 20));
      else rb = $urandom;
      run_op("rand", r_rem, r_sgn, ra, rb, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
